job_done_arbiter: RTL and testbench
===================================

JOB_DONE_ARBITER -- requirements
Module: job_done_arbiter

Interface
REQ-001 SHALL have parameter ENG_NUM, default 8, number of engine done channels (1..32).
REQ-002 SHALL have parameter ENG_ID_BASE, default 0, 9-bit job-slot id reported for channel 0; channel k reports ENG_ID_BASE+k.
REQ-003 SHALL have port clk, input, 1, clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port eng_done_valid_i, input, ENG_NUM, per-engine completion request.
REQ-006 SHALL have port eng_done_code_i, input, 32*ENG_NUM, per-engine return code; channel k occupies bits [32k+31:32k].
REQ-007 SHALL have port eng_done_ready_o, output, ENG_NUM, per-engine accept, one-hot or zero.
REQ-008 SHALL have port complete_ready_i, input, 1, space available in the downstream completion FIFO.
REQ-009 SHALL have port complete_push_o, output, 1, single-cycle write enable to the downstream FIFO.
REQ-010 SHALL have port return_data_o, output, 41, {job id[8:0], return code[31:0]}.
REQ-011 SHALL have port arb_enable_i, input, 1, when low, no new request is granted.
REQ-012 SHALL have port cmpl_cnt_o, output, 32, count of completions pushed downstream.

Function
REQ-013 SHALL hold one completion in a holding register (hold_vld, hold_data[40:0]).
REQ-014 SHALL grant, in a cycle where arb_enable_i=1 and the holding register is free or freeing, exactly one valid channel chosen round-robin, starting from the channel after the last grant.
REQ-015 SHALL assert eng_done_ready_o[k] combinationally in the grant cycle only, and load hold_data={ENG_ID_BASE+k (9-bit wrap), code_k} at the next edge.
REQ-016 SHALL compute complete_push_o = hold_vld & complete_ready_i combinationally, with return_data_o = hold_data; push SHALL never assert while complete_ready_i=0.
REQ-017 SHALL treat the holding register as freeing in a cycle where complete_push_o=1; grant and push in the same cycle give sustained throughput of 1 completion/cycle.
REQ-018 SHALL give a request-to-push latency of 1 cycle: grant in cycle N, push in cycle N+1 if complete_ready_i=1.
REQ-019 SHALL, when hold_vld=1 and complete_ready_i=0, hold hold_data stable and deassert all eng_done_ready_o.
REQ-020 SHALL update the round-robin pointer only on a grant; with no valid requests, the pointer SHALL remain unchanged.
REQ-021 SHALL require engines to keep valid/code stable until ready; a request dropped before grant is never reported.
REQ-022 SHALL finish delivery of a completion already in hold_vld when arb_enable_i falls.
REQ-023 SHALL increment cmpl_cnt_o by 1 per complete_push_o, wrapping modulo 2^32.

Reset
REQ-024 SHALL reset hold_vld=0, hold_data=0, RR pointer so channel 0 has highest priority, and cmpl_cnt_o=0.
REQ-025 SHALL drive eng_done_ready_o=0, complete_push_o=0 and return_data_o=0 while rst_n=0.
REQ-026 SHALL discard a pending held completion on reset mid-operation; it SHALL NOT be pushed after release.

Structure
REQ-027 SHALL take the shared package constants JOB_ID_W=9, RET_CODE_W=32 and CMPL_W=41, used by this block and the completion writer.
REQ-028 SHALL implement the round-robin arbiter as one sub-module, rr_arbiter (request vector, enable -> one-hot grant, pointer update).

Verification
REQ-029 Single request: ENG_NUM=8, ENG_ID_BASE=0x10, ch3 valid with code 0xDEADBEEF, ready=1 -> ready_o=0x08 for 1 cycle; next cycle push=1 and return_data=0x13_DEADBEEF; cmpl_cnt=1.
REQ-030 Fairness: all 8 channels valid continuously, ready=1 -> grants 0,1,...,7,0 on consecutive cycles; push every cycle from cycle 1.
REQ-031 Backpressure: complete_ready_i=0 for 5 cycles while ch1 and ch2 are valid -> one held entry; no push; ready_o=0; after release, pushes ch1 then ch2 with no loss or duplication.
REQ-032 Enable gating: arb_enable_i=0 with hold_vld=1 and ch5 valid -> held entry pushed; ch5 not granted until enable=1.
REQ-033 Reset mid-operation: assert rst_n while hold_vld=1 and ready=0 -> after release, no push, cmpl_cnt=0, next grant goes to ch0 first.
REQ-034 Counter wrap: preload so cmpl_cnt=0xFFFFFFFF, one push -> cmpl_cnt=0x00000000.

Source files
------------

// File: rtl/job_done_arbiter_pkg.sv
// Widths shared by the job-done arbiter and the completion writer that drains its FIFO.
package job_done_arbiter_pkg;

    localparam int JOB_ID_W   = 9;
    localparam int RET_CODE_W = 32;
    localparam int CMPL_W     = JOB_ID_W + RET_CODE_W;

    typedef struct packed {
        logic [JOB_ID_W-1:0]   job_id;
        logic [RET_CODE_W-1:0] code;
    } cmpl_t;

endpackage

// File: rtl/job_done_arbiter_rr.sv
// Round-robin arbiter: one-hot grant among requests, starting after the last winner.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // ptr_q is the channel with highest priority in the current cycle
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int   idx;
        logic found;
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        if (en_i) begin
            for (int i = 0; i < N; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= N) idx = idx - N;
                if (!found && req_i[idx]) begin
                    found      = 1'b1;
                    gnt_o[idx] = 1'b1;
                    ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/job_done_arbiter.sv
// Collects per-engine completions round-robin into a one-entry holding register
// that pushes into the downstream completion FIFO, sustaining one completion per cycle.
module job_done_arbiter
    import job_done_arbiter_pkg::*;
#(
    parameter int                  ENG_NUM     = 8,
    parameter logic [JOB_ID_W-1:0] ENG_ID_BASE = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ENG_NUM-1:0]        eng_done_valid_i,
    input  logic [32*ENG_NUM-1:0]     eng_done_code_i,
    output logic [ENG_NUM-1:0]        eng_done_ready_o,
    input  logic                      complete_ready_i,
    output logic                      complete_push_o,
    output logic [CMPL_W-1:0]         return_data_o,
    input  logic                      arb_enable_i,
    output logic [31:0]               cmpl_cnt_o
);

    logic               hold_vld_q, hold_vld_d;
    cmpl_t              hold_data_q, hold_data_d;
    logic [31:0]        cmpl_cnt_q, cmpl_cnt_d;
    logic               arb_en;
    logic [ENG_NUM-1:0] gnt;

    assign complete_push_o = hold_vld_q & complete_ready_i;

    // Grant only when the holding slot is empty or being drained this cycle;
    // rst_n gating keeps ready_o low throughout reset.
    assign arb_en = arb_enable_i & (~hold_vld_q | complete_ready_i) & rst_n;

    rr_arbiter #(.N(ENG_NUM)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (eng_done_valid_i),
        .en_i  (arb_en),
        .gnt_o (gnt)
    );

    assign eng_done_ready_o = gnt;
    assign return_data_o    = hold_data_q;
    assign cmpl_cnt_o       = cmpl_cnt_q;

    always_comb begin
        hold_vld_d  = hold_vld_q & ~complete_push_o;
        hold_data_d = hold_data_q;
        cmpl_cnt_d  = cmpl_cnt_q + 32'(complete_push_o);
        for (int k = 0; k < ENG_NUM; k++) begin
            if (gnt[k]) begin
                hold_vld_d         = 1'b1;
                hold_data_d.job_id = ENG_ID_BASE + JOB_ID_W'(k);
                hold_data_d.code   = eng_done_code_i[k*RET_CODE_W +: RET_CODE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            cmpl_cnt_q  <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            cmpl_cnt_q  <= cmpl_cnt_d;
        end
    end

endmodule

// File: tb/tb_job_done_arbiter.sv
// Directed bench for job_done_arbiter: inputs change on the falling edge, outputs checked 1ns later.
module tb_job_done_arbiter;

    localparam int         ENG_NUM = 8;
    localparam logic [8:0] BASE    = 9'h010;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [ENG_NUM-1:0]    valid = '0;
    logic [32*ENG_NUM-1:0] code = '0;
    logic [ENG_NUM-1:0]    ready_o;
    logic                  ready = 1'b0;
    logic                  push;
    logic [40:0]           data;
    logic                  en = 1'b0;
    logic [31:0]           cnt;

    int errors = 0;
    int checks = 0;

    job_done_arbiter #(.ENG_NUM(ENG_NUM), .ENG_ID_BASE(BASE)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .eng_done_valid_i (valid),
        .eng_done_code_i  (code),
        .eng_done_ready_o (ready_o),
        .complete_ready_i (ready),
        .complete_push_o  (push),
        .return_data_o    (data),
        .arb_enable_i     (en),
        .cmpl_cnt_o       (cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; valid = '0; ready = 1'b0; en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; valid = '1; ready = 1'b1; en = 1'b1;
        #1;
        checks++; if (ready_o !== 8'h00) begin errors++; $display("FAIL reset_ready ready_o=%h exp=00", ready_o); end
        checks++; if (push !== 1'b0) begin errors++; $display("FAIL reset_push push=%b exp=0", push); end
        checks++; if (data !== 41'h0) begin errors++; $display("FAIL reset_data data=%h exp=0", data); end
        checks++; if (cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt cnt=%h exp=0", cnt); end
        @(negedge clk);
        valid = '0; ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        valid = 8'h08; code[3*32 +: 32] = 32'hDEADBEEF; ready = 1'b1; en = 1'b1;
        #1;
        checks++; if (ready_o !== 8'h08) begin errors++; $display("FAIL single_grant ready_o=%h exp=08", ready_o); end
        checks++; if (push !== 1'b0) begin errors++; $display("FAIL single_nopush push=%b exp=0", push); end
        @(negedge clk);
        valid = '0;
        #1;
        checks++; if (ready_o !== 8'h00) begin errors++; $display("FAIL single_ready_once ready_o=%h exp=00", ready_o); end
        checks++; if (push !== 1'b1) begin errors++; $display("FAIL single_push push=%b exp=1", push); end
        checks++; if (data !== {9'h013, 32'hDEADBEEF}) begin errors++; $display("FAIL single_data data=%h exp=%h", data, {9'h013, 32'hDEADBEEF}); end
        @(negedge clk);
        #1;
        checks++; if (cnt !== 32'd1) begin errors++; $display("FAIL single_cnt cnt=%h exp=1", cnt); end
        checks++; if (push !== 1'b0) begin errors++; $display("FAIL single_push_done push=%b exp=0", push); end
    endtask

    task automatic test_fairness();
        logic [7:0]  exp_gnt;
        logic [40:0] exp_data;
        do_reset();
        for (int k = 0; k < ENG_NUM; k++) code[k*32 +: 32] = 32'hC0DE0000 + 32'(k);
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            valid = '1; ready = 1'b1; en = 1'b1;
            #1;
            exp_gnt = 8'b1 << (c % 8);
            checks++; if (ready_o !== exp_gnt) begin errors++; $display("FAIL fair_grant c=%0d ready_o=%h exp=%h", c, ready_o, exp_gnt); end
            checks++; if (push !== (c > 0)) begin errors++; $display("FAIL fair_push c=%0d push=%b exp=%b", c, push, (c > 0)); end
            if (c > 0) begin
                exp_data = {BASE + 9'((c - 1) % 8), 32'hC0DE0000 + 32'((c - 1) % 8)};
                checks++; if (data !== exp_data) begin errors++; $display("FAIL fair_data c=%0d data=%h exp=%h", c, data, exp_data); end
            end
        end
        @(negedge clk);
        valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        valid = 8'h06; code[1*32 +: 32] = 32'h11111111; code[2*32 +: 32] = 32'h22222222;
        ready = 1'b0; en = 1'b1;
        #1;
        checks++; if (ready_o !== 8'h02) begin errors++; $display("FAIL bp_first_grant ready_o=%h exp=02", ready_o); end
        checks++; if (push !== 1'b0) begin errors++; $display("FAIL bp_first_push push=%b exp=0", push); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            valid = 8'h04;
            #1;
            checks++; if (ready_o !== 8'h00) begin errors++; $display("FAIL bp_stall_ready c=%0d ready_o=%h exp=00", c, ready_o); end
            checks++; if (push !== 1'b0) begin errors++; $display("FAIL bp_stall_push c=%0d push=%b exp=0", c, push); end
            checks++; if (data !== {9'h011, 32'h11111111}) begin errors++; $display("FAIL bp_hold_data c=%0d data=%h", c, data); end
        end
        @(negedge clk);
        ready = 1'b1;
        #1;
        checks++; if (push !== 1'b1) begin errors++; $display("FAIL bp_push1 push=%b exp=1", push); end
        checks++; if (data !== {9'h011, 32'h11111111}) begin errors++; $display("FAIL bp_data1 data=%h", data); end
        checks++; if (ready_o !== 8'h04) begin errors++; $display("FAIL bp_grant2 ready_o=%h exp=04", ready_o); end
        @(negedge clk);
        valid = '0;
        #1;
        checks++; if (push !== 1'b1) begin errors++; $display("FAIL bp_push2 push=%b exp=1", push); end
        checks++; if (data !== {9'h012, 32'h22222222}) begin errors++; $display("FAIL bp_data2 data=%h", data); end
        checks++; if (ready_o !== 8'h00) begin errors++; $display("FAIL bp_idle_ready ready_o=%h exp=00", ready_o); end
        @(negedge clk);
        #1;
        checks++; if (push !== 1'b0) begin errors++; $display("FAIL bp_nodup push=%b exp=0", push); end
        checks++; if (cnt !== 32'd2) begin errors++; $display("FAIL bp_cnt cnt=%h exp=2", cnt); end
    endtask

    task automatic test_enable();
        do_reset();
        @(negedge clk);
        valid = 8'h01; code[0 +: 32] = 32'hAAAA0000; ready = 1'b0; en = 1'b1;
        #1;
        checks++; if (ready_o !== 8'h01) begin errors++; $display("FAIL en_grant0 ready_o=%h exp=01", ready_o); end
        @(negedge clk);
        valid = 8'h20; code[5*32 +: 32] = 32'h55555555; en = 1'b0; ready = 1'b1;
        #1;
        checks++; if (push !== 1'b1) begin errors++; $display("FAIL en_drain_push push=%b exp=1", push); end
        checks++; if (data !== {9'h010, 32'hAAAA0000}) begin errors++; $display("FAIL en_drain_data data=%h", data); end
        checks++; if (ready_o !== 8'h00) begin errors++; $display("FAIL en_gated ready_o=%h exp=00", ready_o); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            checks++; if (ready_o !== 8'h00) begin errors++; $display("FAIL en_gated_idle c=%0d ready_o=%h exp=00", c, ready_o); end
            checks++; if (push !== 1'b0) begin errors++; $display("FAIL en_idle_push c=%0d push=%b exp=0", c, push); end
        end
        @(negedge clk);
        en = 1'b1;
        #1;
        checks++; if (ready_o !== 8'h20) begin errors++; $display("FAIL en_grant5 ready_o=%h exp=20", ready_o); end
        @(negedge clk);
        valid = '0;
        #1;
        checks++; if (push !== 1'b1) begin errors++; $display("FAIL en_push5 push=%b exp=1", push); end
        checks++; if (data !== {9'h015, 32'h55555555}) begin errors++; $display("FAIL en_data5 data=%h", data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        valid = 8'h08; code[3*32 +: 32] = 32'h33333333; code[0 +: 32] = 32'h00C0FFEE;
        ready = 1'b0; en = 1'b1;
        #1;
        checks++; if (ready_o !== 8'h08) begin errors++; $display("FAIL rm_grant3 ready_o=%h exp=08", ready_o); end
        @(negedge clk);
        valid = '0;
        #1;
        checks++; if (push !== 1'b0) begin errors++; $display("FAIL rm_held push=%b exp=0", push); end
        @(negedge clk);
        rst_n = 1'b0; valid = '1; ready = 1'b1;
        #1;
        checks++; if (push !== 1'b0) begin errors++; $display("FAIL rm_in_reset_push push=%b exp=0", push); end
        checks++; if (ready_o !== 8'h00) begin errors++; $display("FAIL rm_in_reset_ready ready_o=%h exp=00", ready_o); end
        checks++; if (data !== 41'h0) begin errors++; $display("FAIL rm_in_reset_data data=%h exp=0", data); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (push !== 1'b0) begin errors++; $display("FAIL rm_discard push=%b exp=0", push); end
        checks++; if (ready_o !== 8'h01) begin errors++; $display("FAIL rm_ptr_reset ready_o=%h exp=01", ready_o); end
        checks++; if (cnt !== 32'h0) begin errors++; $display("FAIL rm_cnt cnt=%h exp=0", cnt); end
        @(negedge clk);
        valid = '0;
        #1;
        checks++; if (data !== {9'h010, 32'h00C0FFEE}) begin errors++; $display("FAIL rm_ch0_data data=%h", data); end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        @(negedge clk);
        force dut.cmpl_cnt_q = 32'hFFFFFFFF;
        valid = 8'h01; code[0 +: 32] = 32'h0BADF00D; ready = 1'b1; en = 1'b1;
        #1;
        release dut.cmpl_cnt_q;
        checks++; if (ready_o !== 8'h01) begin errors++; $display("FAIL wrap_grant ready_o=%h exp=01", ready_o); end
        @(negedge clk);
        valid = '0;
        #1;
        checks++; if (push !== 1'b1) begin errors++; $display("FAIL wrap_push push=%b exp=1", push); end
        checks++; if (cnt !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_pre cnt=%h exp=ffffffff", cnt); end
        @(negedge clk);
        #1;
        checks++; if (cnt !== 32'h00000000) begin errors++; $display("FAIL wrap_cnt cnt=%h exp=0", cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_cnt_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
